csr_rmw: RTL and testbench



---
 rtl/csr_pkg.sv | 43 ++++
 rtl/csr_rmw_if.sv | 33 +++
 rtl/csr_alu.sv | 27 ++
 rtl/csr_rmw.sv | 142 ++++++++++++++
 tb/tb_csr_rmw.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared types and helpers for the CSR read-modify-write sequencer.
// Holds the FSM state enum, funct3 encodings, privilege levels and op decode helpers.
`ifndef XLEN
`define XLEN 32
`endif

package csr_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } csr_state_t;

   localparam logic [2:0] OP_RW  = 3'b001;
   localparam logic [2:0] OP_RS  = 3'b010;
   localparam logic [2:0] OP_RC  = 3'b011;
   localparam logic [2:0] OP_RWI = 3'b101;
   localparam logic [2:0] OP_RSI = 3'b110;
   localparam logic [2:0] OP_RCI = 3'b111;

   localparam logic [1:0] PRV_U = 2'd0;
   localparam logic [1:0] PRV_S = 2'd1;
   localparam logic [1:0] PRV_M = 2'd3;

   // funct3 x00 is not a CSR instruction
   function automatic logic op_valid(input logic [2:0] op);
      return op[1:0] != 2'b00;
   endfunction

   // CSRRW / CSRRWI (low bits 01 regardless of the immediate bit)
   function automatic logic op_is_rw(input logic [2:0] op);
      return op[1:0] == 2'b01;
   endfunction

   // set/clear with a zero operand leave the CSR untouched
   function automatic logic wr_needed(input logic [2:0] op,
                                      input logic       rs1z);
      return op_is_rw(op) || !rs1z;
   endfunction

endpackage

// File: rtl/csr_rmw_if.sv
// Bus between the RMW sequencer and the CSR address decode/mux.
// master: rd/wr strobes, raddr, wdata out, rdata in; slave: the decoder side.
`ifndef XLEN
`define XLEN 32
`endif

interface csr_rmw_if #(
   parameter int XLEN = `XLEN
) ();

   logic            rd;
   logic            wr;
   logic [11:0]     raddr;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] rdata;

   modport master (
      output rd,
      output wr,
      output raddr,
      output wdata,
      input  rdata
   );

   modport slave (
      input  rd,
      input  wr,
      input  raddr,
      input  wdata,
      output rdata
   );

endinterface

// File: rtl/csr_alu.sv
// Combinational new-value computation for CSR write/set/clear.
// Ports: op (funct3), old (current CSR value), src (rs1/zimm) -> wdata.
`ifndef XLEN
`define XLEN 32
`endif

module csr_alu
   import csr_pkg::*;
#(
   parameter int XLEN = `XLEN
) (
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] old,
   input  logic [XLEN-1:0] src,
   output logic [XLEN-1:0] wdata
);

   always_comb begin
      wdata = src;
      case (op)
         OP_RS, OP_RSI: wdata = old | src;
         OP_RC, OP_RCI: wdata = old & ~src;
         default:       wdata = src;
      endcase
   end

endmodule

// File: rtl/csr_rmw.sv
// CSR read-modify-write sequencer: IDLE -> READ -> WRITE -> DONE, with privilege
// and read-only checks. Ports: clk, rstn (sync, active-low), execute-side request
// (csr_req/op/addr/src/rs1_zero/rd_zero/prv/kill, csr_ready), decoder bus (bus),
// completion (csr_done/csr_result/csr_ill). Define CSR_FAST_EN to skip WRITE
// when no write is needed.
`ifndef XLEN
`define XLEN 32
`endif

module csr_rmw
   import csr_pkg::*;
#(
   parameter int XLEN = `XLEN
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            csr_req,
   output logic            csr_ready,
   input  logic [2:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_src,
   input  logic            rs1_zero,
   input  logic            rd_zero,
   input  logic [1:0]      prv,
   input  logic            kill,
   csr_rmw_if.master       bus,
   output logic            csr_done,
   output logic [XLEN-1:0] csr_result,
   output logic            csr_ill
);

   csr_state_t      state;
   logic [2:0]      op_q;
   logic [XLEN-1:0] src_q;
   logic            rs1z_q;
   logic [XLEN-1:0] old_q;

   logic            acc;
   logic            acc_ill;
   logic            wneed_q;
   logic [XLEN-1:0] old_now;
   logic [XLEN-1:0] alu_out;
   logic            fast;

`ifdef CSR_FAST_EN
   assign fast = 1'b1;
`else
   assign fast = 1'b0;
`endif

   assign acc = csr_req && !kill;

   // read-only space is addr[11:10]==11; only a real write faults there
   assign acc_ill = (csr_addr[9:8] > prv)
                 || !op_valid(csr_op)
                 || ((csr_addr[11:10] == 2'b11)
                     && wr_needed(csr_op, rs1_zero));

   assign wneed_q = wr_needed(op_q, rs1z_q);

   // a suppressed read returns zero as the old value
   assign old_now = bus.rd ? bus.rdata : '0;

   assign csr_ready = (state == S_IDLE);

   csr_alu #(
      .XLEN (XLEN)
   ) u_alu (
      .op    (op_q),
      .old   (old_now),
      .src   (src_q),
      .wdata (alu_out)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= S_IDLE;
         op_q       <= '0;
         src_q      <= '0;
         rs1z_q     <= 1'b0;
         old_q      <= '0;
         bus.rd     <= 1'b0;
         bus.wr     <= 1'b0;
         bus.raddr  <= '0;
         bus.wdata  <= '0;
         csr_done   <= 1'b0;
         csr_result <= '0;
         csr_ill    <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               csr_done <= 1'b0;
               csr_ill  <= 1'b0;
               if (acc) begin
                  op_q      <= csr_op;
                  src_q     <= csr_src;
                  rs1z_q    <= rs1_zero;
                  bus.raddr <= csr_addr;
                  if (acc_ill) begin
                     state      <= S_DONE;
                     csr_done   <= 1'b1;
                     csr_ill    <= 1'b1;
                     csr_result <= '0;
                  end else begin
                     state  <= S_READ;
                     bus.rd <= !(rd_zero && op_is_rw(csr_op));
                  end
               end
            end
            S_READ: begin
               bus.rd <= 1'b0;
               if (kill) begin
                  state <= S_IDLE;
               end else if (fast && !wneed_q) begin
                  state      <= S_DONE;
                  old_q      <= old_now;
                  csr_done   <= 1'b1;
                  csr_result <= old_now;
               end else begin
                  state     <= S_WRITE;
                  old_q     <= old_now;
                  bus.wr    <= wneed_q;
                  bus.wdata <= alu_out;
               end
            end
            S_WRITE: begin
               bus.wr     <= 1'b0;
               state      <= S_DONE;
               csr_done   <= 1'b1;
               csr_result <= old_q;
            end
            S_DONE: begin
               state    <= S_IDLE;
               csr_done <= 1'b0;
               csr_ill  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_rmw.sv
// Directed self-checking bench for csr_rmw.
// Drives inputs on negedge, samples outputs on the following negedge.
`ifndef XLEN
`define XLEN 32
`endif

module tb_csr_rmw;
   import csr_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        csr_req;
   logic        csr_ready;
   logic [2:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_src;
   logic        rs1_zero;
   logic        rd_zero;
   logic [1:0]  prv;
   logic        kill;
   logic        csr_done;
   logic [31:0] csr_result;
   logic        csr_ill;

   int n_checks = 0;
   int n_fail   = 0;

   csr_rmw_if #(.XLEN(32)) bus ();

   csr_rmw #(.XLEN(32)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .csr_req    (csr_req),
      .csr_ready  (csr_ready),
      .csr_op     (csr_op),
      .csr_addr   (csr_addr),
      .csr_src    (csr_src),
      .rs1_zero   (rs1_zero),
      .rd_zero    (rd_zero),
      .prv        (prv),
      .kill       (kill),
      .bus        (bus),
      .csr_done   (csr_done),
      .csr_result (csr_result),
      .csr_ill    (csr_ill)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [11:0] addr,
                        input logic [31:0] src, input logic rs1z,
                        input logic rdz);
      csr_op   = op;
      csr_addr = addr;
      csr_src  = src;
      rs1_zero = rs1z;
      rd_zero  = rdz;
      csr_req  = 1'b1;
      @(negedge clk);
      csr_req  = 1'b0;
   endtask

   task automatic run_legal(input string t, input logic [2:0] op,
                            input logic [11:0] addr, input logic [31:0] src,
                            input logic rs1z, input logic rdz,
                            input logic [31:0] rdat, input logic exp_rd,
                            input logic exp_wr, input logic [31:0] exp_wd,
                            input logic [31:0] exp_res);
      logic skip;
`ifdef CSR_FAST_EN
      skip = !exp_wr;
`else
      skip = 1'b0;
`endif
      bus.rdata = rdat;
      issue(op, addr, src, rs1z, rdz);
      chk({t, ".c1.rd"}, bus.rd, exp_rd);
      chk({t, ".c1.wr"}, bus.wr, 0);
      chk({t, ".c1.raddr"}, bus.raddr, addr);
      chk({t, ".c1.ready"}, csr_ready, 0);
      if (!skip) begin
         @(negedge clk);
         chk({t, ".c2.rd"}, bus.rd, 0);
         chk({t, ".c2.wr"}, bus.wr, exp_wr);
         chk({t, ".c2.done"}, csr_done, 0);
         if (exp_wr) chk({t, ".c2.wdata"}, bus.wdata, exp_wd);
      end
      @(negedge clk);
      chk({t, ".done"}, csr_done, 1);
      chk({t, ".result"}, csr_result, exp_res);
      chk({t, ".ill"}, csr_ill, 0);
      chk({t, ".d.wr"}, bus.wr, 0);
      @(negedge clk);
      chk({t, ".post.done"}, csr_done, 0);
      chk({t, ".post.ready"}, csr_ready, 1);
   endtask

   task automatic run_ill(input string t, input logic [2:0] op,
                          input logic [11:0] addr, input logic [31:0] src,
                          input logic rs1z);
      bus.rdata = 32'hBAD0_BAD0;
      issue(op, addr, src, rs1z, 1'b0);
      chk({t, ".done"}, csr_done, 1);
      chk({t, ".ill"}, csr_ill, 1);
      chk({t, ".rd"}, bus.rd, 0);
      chk({t, ".wr"}, bus.wr, 0);
      chk({t, ".result"}, csr_result, 0);
      @(negedge clk);
      chk({t, ".post.done"}, csr_done, 0);
      chk({t, ".post.ill"}, csr_ill, 0);
      chk({t, ".post.ready"}, csr_ready, 1);
      chk({t, ".post.rd"}, bus.rd, 0);
   endtask

   initial begin
      rstn      = 1'b0;
      csr_req   = 1'b0;
      csr_op    = 3'b000;
      csr_addr  = '0;
      csr_src   = '0;
      rs1_zero  = 1'b0;
      rd_zero   = 1'b0;
      prv       = PRV_M;
      kill      = 1'b0;
      bus.rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst.ready", csr_ready, 1);
      chk("rst.rd", bus.rd, 0);
      chk("rst.wr", bus.wr, 0);
      chk("rst.raddr", bus.raddr, 0);
      chk("rst.done", csr_done, 0);
      chk("rst.ill", csr_ill, 0);
      chk("rst.result", csr_result, 0);
      rstn = 1'b1;
      @(negedge clk);

      run_legal("rw", OP_RW, 12'h340, 32'hDEAD, 0, 0, 32'h1234,
                1, 1, 32'hDEAD, 32'h1234);
      run_legal("rs", OP_RS, 12'h300, 32'h2, 0, 0, 32'h8,
                1, 1, 32'hA, 32'h8);
      run_legal("rc", OP_RC, 12'h300, 32'h8, 0, 0, 32'hA,
                1, 1, 32'h2, 32'hA);
      run_legal("rwi", OP_RWI, 12'h340, 32'h5, 0, 0, 32'h11,
                1, 1, 32'h5, 32'h11);

      // reset during WRITE
      bus.rdata = 32'hAA;
      issue(OP_RW, 12'h341, 32'h77, 0, 0);
      @(negedge clk);
      chk("rstw.wr", bus.wr, 1);
      rstn = 1'b0;
      @(negedge clk);
      chk("rstw.wr0", bus.wr, 0);
      chk("rstw.rd0", bus.rd, 0);
      chk("rstw.done", csr_done, 0);
      chk("rstw.ill", csr_ill, 0);
      chk("rstw.ready", csr_ready, 1);
      chk("rstw.raddr", bus.raddr, 0);
      chk("rstw.result", csr_result, 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("rstw.idle.done", csr_done, 0);

      prv = PRV_U;
      run_legal("cyc", OP_RS, 12'hC00, 32'h0, 1, 0, 32'h77,
                1, 0, 32'h0, 32'h77);
      prv = PRV_M;
      run_ill("ro", OP_RW, 12'hC00, 32'h1, 0);
      prv = PRV_U;
      run_ill("prv", OP_RS, 12'h300, 32'h1, 0);
      prv = PRV_M;
      run_ill("op0", 3'b000, 12'h340, 32'h1, 0);

      // kill during READ
      bus.rdata = 32'h99;
      issue(OP_RW, 12'h340, 32'h3, 0, 0);
      chk("kr.rd", bus.rd, 1);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kr.ready", csr_ready, 1);
      chk("kr.wr", bus.wr, 0);
      chk("kr.done", csr_done, 0);
      @(negedge clk);
      chk("kr.wr2", bus.wr, 0);
      chk("kr.done2", csr_done, 0);

      // kill with request in IDLE
      kill = 1'b1;
      issue(OP_RW, 12'h340, 32'h3, 0, 0);
      kill = 1'b0;
      chk("ki.ready", csr_ready, 1);
      chk("ki.rd", bus.rd, 0);
      @(negedge clk);
      chk("ki.wr", bus.wr, 0);
      chk("ki.done", csr_done, 0);

      run_legal("rdz", OP_RW, 12'h340, 32'h9, 0, 1, 32'h55,
                0, 1, 32'h9, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no end expected end");
      $fatal(1, "timeout");
   end

endmodule
